afe_multi_ch_calib_ctrl: RTL and testbench



---
 rtl/afe_ctrl_pkg.sv | 33 +++
 rtl/afe_window_stats.sv | 34 +++
 rtl/afe_multi_ch_calib_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_afe_multi_ch_calib_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/afe_ctrl_pkg.sv
// Shared state encoding, default calibration constants and width helper for the
// multi-channel AFE calibration controller.
package afe_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DC_CAL,
        PGA_CAL,
        OPERATE,
        ERROR
    } afe_state_e;

    localparam int unsigned DEF_NUM_CH     = 2;
    localparam int unsigned DEF_ADC_W      = 8;
    localparam int unsigned DEF_DC_W       = 7;
    localparam int unsigned DEF_PGA_W      = 4;
    localparam int unsigned DEF_WIN_LEN    = 500;
    localparam int unsigned DEF_OP_DWELL   = 10;
    localparam int unsigned DEF_DC_INIT    = 127;
    localparam int unsigned DEF_DC_LO      = 116;
    localparam int unsigned DEF_DC_HI      = 140;
    localparam int unsigned DEF_DC_STEP_DN = 4;
    localparam int unsigned DEF_DC_STEP_UP = 3;
    localparam int unsigned DEF_CLIP_LO    = 10;
    localparam int unsigned DEF_CLIP_HI    = 245;
    localparam int unsigned DEF_MAX_ITER   = 64;

    // Index width that stays at least one bit for a single channel.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/afe_window_stats.sv
// Min/max tracker over WIN_LEN samples; eval_c marks the cycle after the window,
// when win_min/win_max hold the result, and the next window starts right after.
module afe_window_stats #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned WIN_LEN = 500
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              clr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] win_min,
    output logic [DATA_W-1:0] win_max,
    output logic              eval_c
);

    localparam int unsigned CNT_W = $clog2(WIN_LEN + 1);

    logic [CNT_W-1:0] cnt;

    assign eval_c = (cnt == CNT_W'(WIN_LEN));

    always_ff @(posedge CLK) begin
        if (rst || clr || eval_c) begin
            cnt     <= '0;
            win_min <= '1;
            win_max <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
            if (din < win_min) win_min <= din;
            if (din > win_max) win_max <= din;
        end
    end

endmodule

// File: rtl/afe_multi_ch_calib_ctrl.sv
// Per-channel DC/PGA calibration followed by round-robin operation with tagged samples.
// Optional AFE_OP_AVG_EN: emit one averaged sample per operating slot instead of raw samples.
module afe_multi_ch_calib_ctrl
    import afe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH     = DEF_NUM_CH,
    parameter int unsigned ADC_W      = DEF_ADC_W,
    parameter int unsigned DC_W       = DEF_DC_W,
    parameter int unsigned PGA_W      = DEF_PGA_W,
    parameter int unsigned WIN_LEN    = DEF_WIN_LEN,
    parameter int unsigned OP_DWELL   = DEF_OP_DWELL,
    parameter int unsigned DC_INIT    = DEF_DC_INIT,
    parameter int unsigned DC_LO      = DEF_DC_LO,
    parameter int unsigned DC_HI      = DEF_DC_HI,
    parameter int unsigned DC_STEP_DN = DEF_DC_STEP_DN,
    parameter int unsigned DC_STEP_UP = DEF_DC_STEP_UP,
    parameter int unsigned CLIP_LO    = DEF_CLIP_LO,
    parameter int unsigned CLIP_HI    = DEF_CLIP_HI,
    parameter int unsigned MAX_ITER   = DEF_MAX_ITER
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic [ADC_W-1:0]          adc_in,
    input  logic                      find_setting,
    output logic [NUM_CH-1:0]         led_en,
    output logic [DC_W-1:0]           dc_comp,
    output logic [PGA_W-1:0]          pga_gain,
    output logic                      clk_filter,
    output logic                      sample_valid,
    output logic [idx_w(NUM_CH)-1:0]  sample_ch,
    output logic [ADC_W-1:0]          sample_data,
    output logic                      busy,
    output logic                      calib_done,
    output logic                      calib_err,
    output logic [NUM_CH-1:0]         ch_err
);

    localparam int unsigned CH_W   = idx_w(NUM_CH);
    localparam int unsigned MID_W  = ADC_W + 1;
    localparam int unsigned ITER_W = $clog2(MAX_ITER + 1);
    localparam int unsigned SLOT_W = $clog2(OP_DWELL);
    localparam int unsigned DC_MAX = (1 << DC_W) - 1;

    afe_state_e state_q, state_d;

    logic [CH_W-1:0]                ch_q, ch_d;
    logic [CH_W-1:0]                op_ch_q, op_ch_d;
    logic [ITER_W-1:0]              iter_q, iter_d;
    logic [SLOT_W-1:0]              slot_q, slot_d;
    logic [NUM_CH-1:0][DC_W-1:0]    dc_store_q, dc_store_d;
    logic [NUM_CH-1:0][PGA_W-1:0]   gain_store_q, gain_store_d;

    logic [NUM_CH-1:0]  led_en_d;
    logic [DC_W-1:0]    dc_comp_d;
    logic [PGA_W-1:0]   pga_gain_d;
    logic [NUM_CH-1:0]  ch_err_d;
    logic               sample_valid_d;
    logic [CH_W-1:0]    sample_ch_d;
    logic [ADC_W-1:0]   sample_data_d;

    logic [ADC_W-1:0]   win_min, win_max;
    logic               win_eval_c;
    logic               win_clr_c;
    logic [MID_W-1:0]   mid_c;
    logic               clip_c;
    logic               store_c;

    // Windows only run while calibrating; a restart always begins a fresh window.
    assign win_clr_c = find_setting || !((state_q == DC_CAL) || (state_q == PGA_CAL));

    afe_window_stats #(
        .DATA_W  (ADC_W),
        .WIN_LEN (WIN_LEN)
    ) u_win (
        .CLK     (CLK),
        .rst     (rst),
        .clr     (win_clr_c),
        .din     (adc_in),
        .win_min (win_min),
        .win_max (win_max),
        .eval_c  (win_eval_c)
    );

    assign mid_c  = (MID_W'(win_max) + MID_W'(win_min)) >> 1;
    assign clip_c = (win_min < ADC_W'(CLIP_LO)) || (win_max > ADC_W'(CLIP_HI));

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        op_ch_d      = op_ch_q;
        iter_d       = iter_q;
        slot_d       = slot_q;
        dc_store_d   = dc_store_q;
        gain_store_d = gain_store_q;
        led_en_d     = led_en;
        dc_comp_d    = dc_comp;
        pga_gain_d   = pga_gain;
        ch_err_d     = ch_err;
        store_c      = 1'b0;

        case (state_q)
            DC_CAL: begin
                if (win_eval_c) begin
                    if (mid_c < MID_W'(DC_LO)) begin
                        if (dc_comp < DC_W'(DC_STEP_DN)) begin
                            state_d = ERROR;
                        end else begin
                            dc_comp_d = dc_comp - DC_W'(DC_STEP_DN);
                            iter_d    = iter_q + ITER_W'(1);
                        end
                    end else if (mid_c > MID_W'(DC_HI)) begin
                        if (dc_comp > DC_W'(DC_MAX - DC_STEP_UP)) begin
                            state_d = ERROR;
                        end else begin
                            dc_comp_d = dc_comp + DC_W'(DC_STEP_UP);
                            iter_d    = iter_q + ITER_W'(1);
                        end
                    end else begin
                        dc_store_d[ch_q] = dc_comp;
                        pga_gain_d       = '0;
                        state_d          = PGA_CAL;
                    end
                    if (iter_d == ITER_W'(MAX_ITER)) state_d = ERROR;
                    if (state_d == ERROR) begin
                        led_en_d       = '0;
                        ch_err_d[ch_q] = 1'b1;
                    end
                end
            end
            PGA_CAL: begin
                if (win_eval_c) begin
                    if (clip_c) begin
                        gain_store_d[ch_q] = (pga_gain == '0) ? '0 : pga_gain - PGA_W'(1);
                        store_c            = 1'b1;
                    end else if (pga_gain != '1) begin
                        pga_gain_d = pga_gain + PGA_W'(1);
                    end else begin
                        gain_store_d[ch_q] = pga_gain;
                        store_c            = 1'b1;
                    end
                    if (store_c) begin
                        if (ch_q == CH_W'(NUM_CH - 1)) begin
                            state_d    = OPERATE;
                            op_ch_d    = '0;
                            slot_d     = '0;
                            led_en_d   = NUM_CH'(1);
                            dc_comp_d  = dc_store_d[0];
                            pga_gain_d = gain_store_d[0];
                        end else begin
                            state_d    = DC_CAL;
                            ch_d       = ch_q + CH_W'(1);
                            iter_d     = '0;
                            led_en_d   = NUM_CH'(1) << ch_d;
                            dc_comp_d  = DC_W'(DC_INIT);
                            pga_gain_d = '0;
                        end
                    end
                end
            end
            OPERATE: begin
                if (slot_q == SLOT_W'(OP_DWELL - 1)) begin
                    slot_d     = '0;
                    op_ch_d    = (op_ch_q == CH_W'(NUM_CH - 1)) ? '0 : op_ch_q + CH_W'(1);
                    led_en_d   = NUM_CH'(1) << op_ch_d;
                    dc_comp_d  = dc_store_q[op_ch_d];
                    pga_gain_d = gain_store_q[op_ch_d];
                end else begin
                    slot_d = slot_q + SLOT_W'(1);
                end
            end
            default: ;
        endcase

        // Restart overrides every other transition.
        if (find_setting) begin
            state_d      = DC_CAL;
            ch_d         = '0;
            op_ch_d      = '0;
            iter_d       = '0;
            slot_d       = '0;
            dc_store_d   = '0;
            gain_store_d = '0;
            led_en_d     = NUM_CH'(1);
            dc_comp_d    = DC_W'(DC_INIT);
            pga_gain_d   = '0;
            ch_err_d     = '0;
        end
    end

`ifdef AFE_OP_AVG_EN
    localparam int unsigned ACC_W = ADC_W + $clog2(OP_DWELL);

    logic [ACC_W-1:0] acc_q, acc_sum_c;

    // Slot average: accumulate slot cycles 1..OP_DWELL-1 and emit on the last one.
    always_comb begin
        acc_sum_c      = ((slot_q == SLOT_W'(1)) ? '0 : acc_q) + ACC_W'(adc_in);
        sample_valid_d = (state_q == OPERATE) && !find_setting &&
                         (slot_q == SLOT_W'(OP_DWELL - 1));
        sample_ch_d    = sample_valid_d ? op_ch_q : sample_ch;
        sample_data_d  = sample_valid_d ? ADC_W'(acc_sum_c / ACC_W'(OP_DWELL - 1)) : sample_data;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            acc_q <= '0;
        end else if (state_q == OPERATE) begin
            acc_q <= acc_sum_c;
        end
    end
`else
    // Raw sample path: every non-settle slot cycle produces a tagged sample.
    always_comb begin
        sample_valid_d = (state_q == OPERATE) && !find_setting && (slot_q != '0);
        sample_ch_d    = sample_valid_d ? op_ch_q : sample_ch;
        sample_data_d  = sample_valid_d ? adc_in : sample_data;
    end
`endif

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            op_ch_q      <= '0;
            iter_q       <= '0;
            slot_q       <= '0;
            dc_store_q   <= '0;
            gain_store_q <= '0;
            led_en       <= '0;
            dc_comp      <= DC_W'(DC_INIT);
            pga_gain     <= '0;
            clk_filter   <= 1'b0;
            sample_valid <= 1'b0;
            sample_ch    <= '0;
            sample_data  <= '0;
            busy         <= 1'b0;
            calib_done   <= 1'b0;
            calib_err    <= 1'b0;
            ch_err       <= '0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            op_ch_q      <= op_ch_d;
            iter_q       <= iter_d;
            slot_q       <= slot_d;
            dc_store_q   <= dc_store_d;
            gain_store_q <= gain_store_d;
            led_en       <= led_en_d;
            dc_comp      <= dc_comp_d;
            pga_gain     <= pga_gain_d;
            clk_filter   <= ~clk_filter;
            sample_valid <= sample_valid_d;
            sample_ch    <= sample_ch_d;
            sample_data  <= sample_data_d;
            busy         <= (state_d == DC_CAL) || (state_d == PGA_CAL);
            calib_done   <= (state_d == OPERATE);
            calib_err    <= (state_d == ERROR);
            ch_err       <= ch_err_d;
        end
    end

endmodule

// File: tb/tb_afe_multi_ch_calib_ctrl.sv
// Self-checking bench for afe_multi_ch_calib_ctrl (default parameters, 2 channels).
// Build with +define+AFE_OP_AVG_EN to check the averaged operating sample path.
module tb_afe_multi_ch_calib_ctrl;

    logic       CLK = 1'b0;
    logic       rst;
    logic [7:0] adc_in;
    logic       find_setting;
    logic [1:0] led_en;
    logic [6:0] dc_comp;
    logic [3:0] pga_gain;
    logic       clk_filter;
    logic       sample_valid;
    logic [0:0] sample_ch;
    logic [7:0] sample_data;
    logic       busy;
    logic       calib_done;
    logic       calib_err;
    logic [1:0] ch_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    afe_multi_ch_calib_ctrl dut (
        .CLK          (CLK),
        .rst          (rst),
        .adc_in       (adc_in),
        .find_setting (find_setting),
        .led_en       (led_en),
        .dc_comp      (dc_comp),
        .pga_gain     (pga_gain),
        .clk_filter   (clk_filter),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_data  (sample_data),
        .busy         (busy),
        .calib_done   (calib_done),
        .calib_err    (calib_err),
        .ch_err       (ch_err)
    );

    // One calibration window: stimulus swing and the outputs expected right after its evaluation.
    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [6:0] dc;
        logic [3:0] pga;
        logic [1:0] led;
        logic       bsy;
        logic       done;
    } win_vec_t;

    win_vec_t   vecs[$];
    logic [7:0] hist[0:79];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push(input int lo, input int hi, input int dc, input int pga,
                                 input int led, input int bsy, input int done);
        win_vec_t v;
        v.lo = 8'(lo); v.hi = 8'(hi); v.dc = 7'(dc); v.pga = 4'(pga);
        v.led = 2'(led); v.bsy = 1'(bsy); v.done = 1'(done);
        vecs.push_back(v);
    endfunction

    // Drive WIN_LEN alternating samples plus the evaluation cycle; returns one cycle after evaluation.
    task automatic run_window(input logic [7:0] lo, input logic [7:0] hi);
        for (int i = 0; i < 501; i++) begin
            adc_in = (i % 2 == 0) ? lo : hi;
            @(negedge CLK);
        end
    endtask

    task automatic pulse_find();
        find_setting = 1'b1;
        @(negedge CLK);
        find_setting = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_led_en"}, led_en, 0);
        check({tag, "_dc_comp"}, dc_comp, 127);
        check({tag, "_pga_gain"}, pga_gain, 0);
        check({tag, "_clk_filter"}, clk_filter, 0);
        check({tag, "_sample_valid"}, sample_valid, 0);
        check({tag, "_sample_ch"}, sample_ch, 0);
        check({tag, "_sample_data"}, sample_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_calib_done"}, calib_done, 0);
        check({tag, "_calib_err"}, calib_err, 0);
        check({tag, "_ch_err"}, ch_err, 0);
    endtask

    initial begin
        // Calibration script: ch0 -> dc 123, gain 2; ch1 -> dc 95, gain 5.
        push(100, 100, 123, 0, 1, 1, 0);
        push(108, 148, 123, 0, 1, 1, 0);
        for (int g = 1; g <= 3; g++) push(108, 148, 123, g, 1, 1, 0);
        push(108, 250, 127, 0, 2, 1, 0);
        for (int k = 1; k <= 8; k++) push(100, 100, 127 - 4 * k, 0, 2, 1, 0);
        push(108, 148, 95, 0, 2, 1, 0);
        for (int g = 1; g <= 6; g++) push(108, 148, 95, g, 2, 1, 0);
        push(108, 250, 123, 2, 1, 0, 1);

        rst          = 1'b1;
        find_setting = 1'b0;
        adc_in       = 8'd0;
        repeat (3) @(negedge CLK);
        check_reset_values("por");
        rst = 1'b0;
        @(negedge CLK);
        check("clk_filter_rise", clk_filter, 1);
        @(negedge CLK);
        check("clk_filter_fall", clk_filter, 0);
        check("idle_busy", busy, 0);

        // Full calibration of both channels.
        pulse_find();
        check("start_led", led_en, 1);
        check("start_busy", busy, 1);
        check("start_dc", dc_comp, 127);
        check("start_pga", pga_gain, 0);
        foreach (vecs[i]) begin
            run_window(vecs[i].lo, vecs[i].hi);
            check($sformatf("win%0d_dc", i), dc_comp, vecs[i].dc);
            check($sformatf("win%0d_pga", i), pga_gain, vecs[i].pga);
            check($sformatf("win%0d_led", i), led_en, vecs[i].led);
            check($sformatf("win%0d_busy", i), busy, vecs[i].bsy);
            check($sformatf("win%0d_done", i), calib_done, vecs[i].done);
            check($sformatf("win%0d_err", i), calib_err, 0);
        end

        // Operation: t is the cycle index within OPERATE, t=0 is slot 0's settle cycle.
        for (int t = 0; t < 60; t++) begin
            int         s;
            int         ch;
            int         ps;
            int         sum;
            bit         vld;
            logic [7:0] ed;
            s  = t / 10;
            ch = s % 2;
            ps = (t > 0) ? (t - 1) / 10 : 0;
            ed = 8'd0;
            check($sformatf("op%0d_led", t), led_en, (ch == 1) ? 2 : 1);
            check($sformatf("op%0d_dc", t), dc_comp, (ch == 1) ? 95 : 123);
            check($sformatf("op%0d_pga", t), pga_gain, (ch == 1) ? 5 : 2);
            check($sformatf("op%0d_done", t), calib_done, 1);
`ifdef AFE_OP_AVG_EN
            vld = (t >= 1) && ((t - 1) % 10 == 9);
            if (vld) begin
                sum = 0;
                for (int j = 1; j < 10; j++) sum += int'(hist[ps * 10 + j]);
                ed = 8'(sum / 9);
            end
`else
            vld = (t >= 1) && ((t - 1) % 10 != 0);
            if (vld) ed = hist[t - 1];
`endif
            check($sformatf("op%0d_valid", t), sample_valid, vld);
            if (vld) begin
                check($sformatf("op%0d_ch", t), sample_ch, ps % 2);
                check($sformatf("op%0d_data", t), sample_data, ed);
            end
            hist[t] = 8'((t * 37 + 11) % 256);
            adc_in  = hist[t];
            @(negedge CLK);
        end

        // Restart from OPERATE.
        pulse_find();
        check("restart_done", calib_done, 0);
        check("restart_busy", busy, 1);
        check("restart_led", led_en, 1);
        check("restart_dc", dc_comp, 127);
        check("restart_pga", pga_gain, 0);
        check("restart_valid", sample_valid, 0);

        // DC underflow on ch0: 127,123,...,3 then the next step would go below 0.
        for (int k = 1; k <= 31; k++) begin
            run_window(8'd0, 8'd0);
            check($sformatf("uflow%0d_dc", k), dc_comp, 127 - 4 * k);
        end
        run_window(8'd0, 8'd0);
        check("uflow_err", calib_err, 1);
        check("uflow_ch_err", ch_err, 1);
        check("uflow_led", led_en, 0);
        check("uflow_busy", busy, 0);
        check("uflow_dc_hold", dc_comp, 3);
        repeat (20) @(negedge CLK);
        check("err_sticky", calib_err, 1);

        // Restart clears errors; then a 2-cycle reset in the middle of DC_CAL.
        pulse_find();
        check("reerr_clear", calib_err, 0);
        check("rech_err_clear", ch_err, 0);
        adc_in = 8'd100;
        repeat (20) @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check_reset_values("midrst");
        rst = 1'b0;
        repeat (600) @(negedge CLK);
        check("post_rst_idle_busy", busy, 0);
        check("post_rst_idle_led", led_en, 0);
        check("post_rst_idle_dc", dc_comp, 127);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
